// File: rtl/rsa_pkg.sv
// rsa_pkg: shared operand-select codes, result-source codes and sequencer states for the RSA core
package rsa_pkg;
  localparam logic [1:0] SEL_RES  = 2'b00;
  localparam logic [1:0] SEL_MSG  = 2'b01;
  localparam logic [1:0] SEL_ONE  = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;
  localparam logic SRC_PROD = 1'b0;
  localparam logic SRC_MUX  = 1'b1;
  typedef enum logic [3:0] {
    IDLE, INIT, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, CV_ISSUE, CV_WAIT, DONE
  } state_e;
endpackage

// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: left-to-right square-and-multiply sequencer around one shared modular multiplier
module rsa_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int CONST_TIME = 1,
  parameter int CONV_OUT   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [EXP_WIDTH-1:0] exponent,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           op_a_sel,
  output logic [1:0]           op_b_sel,
  output logic                 mult_start,
  input  logic                 mult_done,
  output logic                 res_we,
  output logic                 res_src
);
  localparam int CW = $clog2(EXP_WIDTH + 1);
  state_e               state_q, state_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 bit_msb;
  assign bit_msb = exp_q[EXP_WIDTH-1];
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (start) begin
        exp_d   = exponent;
        cnt_d   = CW'(EXP_WIDTH);
        state_d = INIT;
      end
      INIT:      state_d = SQ_ISSUE;
      SQ_ISSUE:  state_d = SQ_WAIT;
      SQ_WAIT:   if (mult_done) state_d = (bit_msb || CONST_TIME != 0) ? MUL_ISSUE : NEXT;
      MUL_ISSUE: state_d = MUL_WAIT;
      MUL_WAIT:  if (mult_done) state_d = NEXT;
      NEXT: begin
        exp_d   = exp_q << 1;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? ((CONV_OUT != 0) ? CV_ISSUE : DONE) : SQ_ISSUE;
      end
      CV_ISSUE:  state_d = CV_WAIT;
      CV_WAIT:   if (mult_done) state_d = DONE;
      default:   state_d = IDLE;
    endcase
  end
  // Everything except res_we is a pure state decode; res_we follows the accepted mult_done
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign mult_start = state_q inside {SQ_ISSUE, MUL_ISSUE, CV_ISSUE};
  assign op_a_sel   = (state_q inside {IDLE, DONE}) ? SEL_ZERO : (state_q == INIT) ? SEL_ONE : SEL_RES;
  assign op_b_sel   = (state_q inside {SQ_ISSUE, SQ_WAIT})   ? SEL_RES :
                      (state_q inside {MUL_ISSUE, MUL_WAIT}) ? SEL_MSG :
                      (state_q inside {CV_ISSUE, CV_WAIT})   ? SEL_ONE : SEL_ZERO;
  assign res_src    = (state_q == INIT) ? SRC_MUX : SRC_PROD;
  assign res_we     = (state_q == INIT) ||
                      (mult_done && (state_q inside {SQ_WAIT, CV_WAIT})) ||
                      (mult_done && state_q == MUL_WAIT && bit_msb);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// tb_rsa_exp_ctrl: directed checks of the exponentiation sequencer, constant-time and variable-time builds side by side
module tb_rsa_exp_ctrl;
  import rsa_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n, start, spur, varlat;
  logic [3:0] exponent;
  int         lat;
  logic       busy_w[2], done_w[2], mst_w[2], mdone_w[2], we_w[2], src_w[2];
  logic [1:0] a_sel_w[2], b_sel_w[2];
  int         mcnt[2], ncall[2];
  int         bcnt[2], nm[2], nw[2], op_busy[2], op_mst[2], op_we[2], done_tot[2], we_tot[2];
  int         bad, stab;
  logic [31:0] sig[2], op_sig[2];
  logic [1:0] ra[2], rb[2];
  logic       arm[2];
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;
  rsa_exp_ctrl #(.EXP_WIDTH(4), .CONST_TIME(1), .CONV_OUT(1)) dut_ct (
    .clk(clk), .rst_n(rst_n), .start(start), .exponent(exponent), .busy(busy_w[0]), .done(done_w[0]),
    .op_a_sel(a_sel_w[0]), .op_b_sel(b_sel_w[0]), .mult_start(mst_w[0]), .mult_done(mdone_w[0]),
    .res_we(we_w[0]), .res_src(src_w[0]));
  rsa_exp_ctrl #(.EXP_WIDTH(4), .CONST_TIME(0), .CONV_OUT(1)) dut_vt (
    .clk(clk), .rst_n(rst_n), .start(start), .exponent(exponent), .busy(busy_w[1]), .done(done_w[1]),
    .op_a_sel(a_sel_w[1]), .op_b_sel(b_sel_w[1]), .mult_start(mst_w[1]), .mult_done(mdone_w[1]),
    .res_we(we_w[1]), .res_src(src_w[1]));
  for (genvar g = 0; g < 2; g++) begin : g_mdone
    assign mdone_w[g] = (mcnt[g] == 1) || spur;
  end
  initial begin
    bad = 0;
    stab = 0;
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; ncall[i] = 0; bcnt[i] = 0; nm[i] = 0; nw[i] = 0; op_busy[i] = 0; op_mst[i] = 0;
      op_we[i] = 0; done_tot[i] = 0; we_tot[i] = 0; sig[i] = 0; op_sig[i] = 0; arm[i] = 0; ra[i] = 0; rb[i] = 0;
    end
  end
  // Multiplier model: done on the L-th cycle after mult_start; varlat alternates L=1 / L=7 per call
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (done_w[i]) ncall[i] <= 0;
      if (mst_w[i]) begin
        mcnt[i]  <= varlat ? ((ncall[i] % 2 == 1) ? 7 : 1) : lat;
        ncall[i] <= ncall[i] + 1;
      end else if (mcnt[i] > 0) mcnt[i] <= mcnt[i] - 1;
    end
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      if (!busy_w[i]) begin
        bcnt[i] <= 0; sig[i] <= 0; nm[i] <= 0; nw[i] <= 0; arm[i] <= 1'b0;
      end else if (done_w[i]) begin
        op_busy[i] <= bcnt[i] + 1; op_sig[i] <= sig[i]; op_mst[i] <= nm[i]; op_we[i] <= nw[i];
        done_tot[i] <= done_tot[i] + 1;
      end else begin
        bcnt[i] <= bcnt[i] + 1;
        if (mst_w[i]) begin
          nm[i] <= nm[i] + 1; arm[i] <= 1'b1; ra[i] <= a_sel_w[i]; rb[i] <= b_sel_w[i];
        end
        if (we_w[i]) begin
          nw[i]  <= nw[i] + 1;
          sig[i] <= {sig[i][29:0], src_w[i] ? 2'b11 : b_sel_w[i]};
        end
      end
      if (we_w[i]) we_tot[i] <= we_tot[i] + 1;
      if (we_w[i] && (!busy_w[i] || (!mdone_w[i] && !src_w[i]))) bad <= bad + 1;
      if (busy_w[i] && arm[i] && mcnt[i] > 0 && !mst_w[i] && (a_sel_w[i] != ra[i] || b_sel_w[i] != rb[i]))
        stab <= stab + 1;
    end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_done();
    int d0 = done_tot[0], d1 = done_tot[1], n = 0;
    while ((done_tot[0] == d0 || done_tot[1] == d1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("timeout", 0, 1);
    @(posedge clk); #1;
  endtask
  task automatic run_op(input logic [3:0] e);
    @(posedge clk); #1;
    start = 1'b1; exponent = e;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
  endtask
  initial begin
    int base_we, base_dn, n;
    rst_n = 1'b0; start = 1'b0; exponent = '0; spur = 1'b0; lat = 2; varlat = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_w[0], 0);
    chk("rst_done", done_w[0], 0);
    chk("rst_asel", a_sel_w[0], 3);
    chk("rst_bsel", b_sel_w[0], 3);
    chk("rst_mst", mst_w[0], 0);
    chk("rst_we", we_w[0], 0);
    rst_n = 1'b1;
    run_op(4'b1011);
    chk("t1_busy", op_busy[0], 33);
    chk("t1_mst", op_mst[0], 9);
    chk("t1_we", op_we[0], 9);
    chk("t1_seq", op_sig[0], 18'b11_00_01_00_00_01_00_01_10);
    chk("t2_busy", op_busy[1], 30);
    chk("t2_mst", op_mst[1], 8);
    chk("t2_we", op_we[1], 9);
    chk("t2_seq", op_sig[1], 18'b11_00_01_00_00_01_00_01_10);
    run_op(4'b0000);
    chk("t3_busy", op_busy[0], 33);
    chk("t3_mst", op_mst[0], 9);
    chk("t3_we", op_we[0], 6);
    chk("t3_seq", op_sig[0], 12'b11_00_00_00_00_10);
    chk("t3_vt_busy", op_busy[1], 21);
    chk("t3_vt_mst", op_mst[1], 5);
    // Reset in the middle of the first MUL_WAIT, with the multiplier result still in flight
    @(posedge clk); #1;
    start = 1'b1; exponent = 4'b1011;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(b_sel_w[0] == SEL_MSG && !mst_w[0]) && n < 100);
    chk("t4_reach_mulwait", int'(n < 100), 1);
    base_dn = done_tot[0];
    rst_n = 1'b0;
    #1;
    chk("t4_busy_ct", busy_w[0], 0);
    chk("t4_busy_vt", busy_w[1], 0);
    chk("t4_asel", a_sel_w[0], 3);
    chk("t4_bsel", b_sel_w[0], 3);
    chk("t4_done", done_w[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base_we = we_tot[0] + we_tot[1];
    repeat (10) @(negedge clk);
    chk("t4_idle_we", we_tot[0] + we_tot[1] - base_we, 0);
    chk("t4_no_done", done_tot[0] - base_dn, 0);
    chk("t4_idle_busy", busy_w[0], 0);
    run_op(4'b1011);
    chk("t4_re_busy", op_busy[0], 33);
    chk("t4_re_seq", op_sig[0], 18'b11_00_01_00_00_01_00_01_10);
    chk("t4_re_vt_busy", op_busy[1], 30);
    // Held start, spurious dones in IDLE and in SQ_ISSUE
    lat = 3;
    base_dn = done_tot[0];
    base_we = we_tot[0];
    @(posedge clk); #1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("t5_idle_spur_we", we_tot[0] - base_we, 0);
    @(posedge clk); #1;
    exponent = 4'b1111;
    for (int i = 0; i < 40; i++) begin
      start = 1'b1;
      spur  = (i == 2);
      @(posedge clk); #1;
    end
    start = 1'b0;
    spur  = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    chk("t5_one_op", done_tot[0] - base_dn, 1);
    chk("t5_busy", op_busy[0], 42);
    chk("t5_mst", op_mst[0], 9);
    chk("t5_we", op_we[0], 10);
    chk("t5_seq", op_sig[0], 20'b11_00_01_00_01_00_01_00_01_10);
    chk("t5_idle", busy_w[0], 0);
    // start asserted exactly in the DONE cycle must not be taken
    lat = 2;
    @(posedge clk); #1;
    start = 1'b1; exponent = 4'b1111;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(b_sel_w[0] == SEL_ONE && mdone_w[0] && !mst_w[0]) && n < 100);
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    chk("t5_done_cycle", done_w[0], 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t5_start_in_done_ct", busy_w[0], 0);
    chk("t5_start_in_done_vt", busy_w[1], 0);
    @(negedge clk);
    chk("t5_still_idle", busy_w[0], 0);
    varlat = 1'b1;
    run_op(4'b1011);
    chk("t6_busy_ct", op_busy[0], 48);
    chk("t6_busy_vt", op_busy[1], 46);
    chk("t6_seq", op_sig[0], 18'b11_00_01_00_00_01_00_01_10);
    chk("sel_stability", stab, 0);
    chk("we_without_done", bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rsa_exp_ctrl.md
Name: rsa_exp_ctrl

Overview:
Sequencer for left-to-right square-and-multiply modular exponentiation around one shared modular multiplier. Drives the two 2-bit operand-mux selects: 00 = result register, 01 = message register, 10 = constant one, 11 = zero. Also drives the multiplier start/done handshake and the result-register write controls. Sits between the SPI/register front end (start, exponent) and the multiplier datapath in the RSA core.

Parameters:
EXP_WIDTH, 8, exponent width in bits; number of square/multiply iterations (>=1).
CONST_TIME, 1, 1 = always issue the multiply step and gate the write by the exponent bit; 0 = skip the multiply when the bit is 0.
CONV_OUT, 1, 1 = append a final multiply-by-one (Montgomery domain exit); 0 = omit it.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
exponent  input  EXP_WIDTH  exponent; latched on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse on completion
op_a_sel  output  2  operand A mux select
op_b_sel  output  2  operand B mux select
mult_start  output  1  one-cycle multiplier launch
mult_done  input  1  multiplier completion pulse
res_we  output  1  result register write enable
res_src  output  1  result write source: 0 = multiplier product, 1 = operand A mux output

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; busy=0, done=0, mult_start=0, res_we=0, res_src=0; op_a_sel=op_b_sel=11; exponent shift register=0; bit counter=0. An in-flight multiplier result is abandoned.
- IDLE: selects=11/11. If start=1, latch exponent into the shift register, set counter=EXP_WIDTH, go to INIT.
- INIT (1 cycle): op_a_sel=10, res_src=1, res_we=1, so result becomes 1. Go to SQ_ISSUE.
- SQ_ISSUE (1 cycle): selects 00/00, mult_start=1. Go to SQ_WAIT.
- SQ_WAIT: hold 00/00. On mult_done, assert res_we=1 with res_src=0 in the same cycle. Then go to MUL_ISSUE if (shift register MSB=1 or CONST_TIME=1), else go to NEXT.
- MUL_ISSUE (1 cycle): selects 00/01, mult_start=1. Go to MUL_WAIT.
- MUL_WAIT: hold 00/01. On mult_done, res_we = shift register MSB (res_src=0). Go to NEXT.
- NEXT (1 cycle): shift the register left by 1, fill with 0, decrement the counter. If the new counter is 0, go to CV_ISSUE when CONV_OUT=1, else DONE. Otherwise go to SQ_ISSUE.
- CV_ISSUE (1 cycle): selects 00/10, mult_start=1. Go to CV_WAIT.
- CV_WAIT: hold 00/10. On mult_done, res_we=1, res_src=0. Go to DONE.
- DONE (1 cycle): done=1, selects 11/11. Go to IDLE. A start arriving in this cycle is ignored.
- Output timing and gating:
  - All outputs are registered or decoded from state only; none depend combinationally on start.
  - mult_done is ignored outside *_WAIT states. A done that coincides with an ISSUE cycle is dropped, so multiplier latency must be >=1.
  - start is ignored while busy=1.
  - Selects are stable for the whole ISSUE and WAIT span.
- Cycle count, with multiplier latency L (done on the L-th cycle after mult_start) and CONST_TIME=1:
  - busy high for 1 + EXP_WIDTH*(2L+3) + CONV_OUT*(L+1) + 1 cycles.
  - This count is independent of the exponent value.

Decomposition:
- Shared package rsa_pkg holds:
  - select constants: SEL_RES=2'b00, SEL_MSG=2'b01, SEL_ONE=2'b10, SEL_ZERO=2'b11;
  - res_src constants: SRC_PROD, SRC_MUX;
  - the state enum typedef (IDLE, INIT, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, CV_ISSUE, CV_WAIT, DONE).
- No sub-module: a single FSM with a shift register and a $clog2(EXP_WIDTH+1) counter. The operand muxes and the multiplier are instantiated by the parent.

Test Plan:
1. EXP_WIDTH=4, CONST_TIME=1, CONV_OUT=1, L=2, exponent=4'b1011, start -> busy high exactly 33 cycles; 9 mult_start pulses; 9 res_we pulses; write-enable sequence INIT, S, M, S, (M gated), S, M, S, M, CV; one done pulse.
2. Same, CONST_TIME=0 -> 8 mult_start pulses; no MUL_ISSUE after bit 2 (value 0); busy = 33 - (2+1) = 30 cycles.
3. exponent=0, CONST_TIME=1 -> every MUL_WAIT write is gated (res_we=0); result writes are INIT, 4 squares and CV only; busy is still 33 cycles.
4. Assert rst_n=0 mid-MUL_WAIT, hold 1 cycle -> immediately: busy=0, selects=11/11, no done. A later mult_done is ignored; a new start runs a full, correct sequence.
5. start held high for 40 cycles, plus spurious mult_done in IDLE and in an ISSUE cycle -> exactly one operation; spurious dones produce no res_we; start in the DONE cycle is not accepted.
6. Variable latency L=1 then L=7 per call -> select stability is checked over the whole WAIT span, and res_we coincides exactly with each accepted mult_done.
